// File: rtl/add_serial_if.sv
// Request/result bundle for the bit-serial adder: start/a/b in, busy/done/sum/cout/ovf out.
interface add_serial_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/add_serial.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, WIDTH cycles per sum.
module add_serial #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  add_serial_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_s;
  logic             carry_s;
  logic             last_s;

  // Full-adder cell on the current LSBs of the operand shift registers.
  always_comb begin
    bit_s   = a_q[0] ^ b_q[0] ^ carry_q;
    carry_s = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    last_s  = (idx_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_s;
        res_d   = {bit_s, res_q[WIDTH-1:1]};
        idx_d   = idx_q + CW'(1);
        busy_d  = 1'b1;
        // carry_q here is the carry into the MSB, so ovf is cin(MSB) ^ cout(MSB).
        if (last_s) begin
          sum_d   = {bit_s, res_q[WIDTH-1:1]};
          cout_d  = carry_s;
          ovf_d   = carry_q ^ carry_s;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
